// File: rtl/uart_tx_drain_if.sv
// rtl/uart_tx_drain_if.sv - byte-queue pop interface between the TX queue and the UART drain
//
// Signals:
//   fifo_data   head byte of the queue, valid whenever fifo_empty==0
//   fifo_empty  queue empty flag (registered inside the queue)
//   fifo_rd     one-cycle pop strobe from the drain
// Modports:
//   master  queue side (drives data/empty, receives the pop)
//   slave   drain side (receives data/empty, drives the pop)
interface uart_tx_drain_if;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd;

    modport master (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd
    );

    modport slave (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd
    );
endinterface

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - pops bytes from the TX queue and serialises them as 8N1/8N2 UART frames
//
// Parameters:
//   CLK_PER_BIT  clk cycles per serial bit (>= 4)
//   STOP_BITS    number of stop bits (1 or 2)
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   fifo   queue pop interface (slave side): fifo_data, fifo_empty in; fifo_rd out
//   txd    registered serial line, idle high
//   busy   registered, high while a frame is in progress
module uart_tx_drain #(
    parameter int CLK_PER_BIT = 868,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_drain_if.slave       fifo,
    output logic                 txd,
    output logic                 busy
);
    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    // Pop decision is combinational so the frame starts the cycle after the
    // pop; the queue's flag is only looked at while idle.
    assign fifo.fifo_rd = !rst && (state == IDLE) && !fifo.fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fifo.fifo_rd) begin
                        shift_reg <= fifo.fifo_data;
                        state     <= START;
                        txd       <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        txd      <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            txd     <= 1'b1;
                        end else begin
                            // Next bit is shift_reg[1] before the shift lands.
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            txd       <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    txd <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        // bit_cnt is reused to count stop bits.
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - directed self-checking bench for uart_tx_drain
module tb_uart_tx_drain;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_drain_if if1 ();
    uart_tx_drain_if if2 ();
    logic txd1, busy1, txd2, busy2;

    uart_tx_drain #(.CLK_PER_BIT(C), .STOP_BITS(1)) dut1 (
        .clk (clk), .rst (rst), .fifo (if1.slave), .txd (txd1), .busy (busy1)
    );
    uart_tx_drain #(.CLK_PER_BIT(C), .STOP_BITS(2)) dut2 (
        .clk (clk), .rst (rst), .fifo (if2.slave), .txd (txd2), .busy (busy2)
    );

    // Simple byte queues feeding each instance.
    logic [7:0] mem1 [0:15];
    logic [7:0] mem2 [0:15];
    int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
    assign if1.fifo_empty = (rd1 == wr1);
    assign if1.fifo_data  = mem1[rd1[3:0]];
    assign if2.fifo_empty = (rd2 == wr2);
    assign if2.fifo_data  = mem2[rd2[3:0]];

    int cyc = 0;
    int pop_log1 [$];
    int pop_log2 [$];
    always @(posedge clk) begin
        if (if1.fifo_rd) begin
            rd1 <= rd1 + 1;
            pop_log1.push_back(cyc);
        end
        if (if2.fifo_rd) begin
            rd2 <= rd2 + 1;
            pop_log2.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    logic sel = 1'b0;
    wire txd_m  = sel ? txd2 : txd1;
    wire busy_m = sel ? busy2 : busy1;
    wire rd_m   = sel ? if2.fifo_rd : if1.fifo_rd;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1[3:0]] = b;
        wr1 = wr1 + 1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2[3:0]] = b;
        wr2 = wr2 + 1;
    endtask

    // Waits (bounded) for a pop strobe, then steps past the pop edge.
    task automatic wait_pop(input int max);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rd_m) begin
                found = 1'b1;
                break;
            end
        end
        check("pop_seen", {31'd0, found}, 32'd1);
        if (found) @(posedge clk);
    endtask

    // Checks every cycle of a frame starting the cycle after a pop and
    // decodes the byte at mid-bit.
    task automatic frame_check(input logic [7:0] b, input int stop_bits);
        logic [7:0] rx;
        logic       exp_bit;
        int         k;
        rx = 8'h00;
        for (int i = 0; i < (9 + stop_bits) * C; i++) begin
            @(negedge clk);
            if (i < C) begin
                exp_bit = 1'b0;
            end else if (i < 9 * C) begin
                k = (i - C) / C;
                exp_bit = b[k];
                if ((i % C) == C / 2) rx[k] = txd_m;
            end else begin
                exp_bit = 1'b1;
            end
            check($sformatf("txd_c%0d", i), {31'd0, txd_m}, {31'd0, exp_bit});
            check($sformatf("busy_c%0d", i), {31'd0, busy_m}, 32'd1);
            check($sformatf("rd_c%0d", i), {31'd0, rd_m}, 32'd0);
        end
        check("decoded", {24'd0, rx}, {24'd0, b});
    endtask

    int n0;
    int bad_rd, bad_txd, bad_busy;

    initial begin
        // 1: reset held with a non-empty queue
        push1(8'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_rd", {31'd0, if1.fifo_rd}, 32'd0);
            check("rst_txd", {31'd0, txd1}, 32'd1);
            check("rst_busy", {31'd0, busy1}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // 2: single byte 0x55
        wait_pop(3);
        frame_check(8'h55, 1);
        @(negedge clk);
        check("t2_idle_busy", {31'd0, busy1}, 32'd0);
        check("t2_idle_txd", {31'd0, txd1}, 32'd1);
        check("t2_idle_rd", {31'd0, if1.fifo_rd}, 32'd0);

        // 3: three bytes back to back
        @(posedge clk); #1;
        push1(8'hA5); push1(8'h3C); push1(8'hFF);
        n0 = pop_log1.size();
        wait_pop(5);
        frame_check(8'hA5, 1);
        wait_pop(2);
        frame_check(8'h3C, 1);
        wait_pop(2);
        frame_check(8'hFF, 1);
        check("t3_pops", pop_log1.size() - n0, 32'd3);
        if (pop_log1.size() - n0 == 3) begin
            check("t3_gap0", pop_log1[n0 + 1] - pop_log1[n0], 32'd41);
            check("t3_gap1", pop_log1[n0 + 2] - pop_log1[n0 + 1], 32'd41);
        end

        // 4: empty queue for 200 cycles
        bad_rd = 0; bad_txd = 0; bad_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if1.fifo_rd !== 1'b0) bad_rd++;
            if (txd1 !== 1'b1) bad_txd++;
            if (busy1 !== 1'b0) bad_busy++;
        end
        check("t4_rd_cycles", bad_rd, 32'd0);
        check("t4_txd_cycles", bad_txd, 32'd0);
        check("t4_busy_cycles", bad_busy, 32'd0);

        // 5: reset during data bit 3 of 0x0F
        @(posedge clk); #1;
        push1(8'h0F);
        wait_pop(5);
        for (int i = 0; i < 17; i++) @(negedge clk);
        check("t5_bit3", {31'd0, txd1}, 32'd1);
        check("t5_busy", {31'd0, busy1}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        push1(8'h81);
        @(negedge clk);
        check("t5_rd_in_rst", {31'd0, if1.fifo_rd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_txd_after", {31'd0, txd1}, 32'd1);
        check("t5_busy_after", {31'd0, busy1}, 32'd0);
        check("t5_rd_after", {31'd0, if1.fifo_rd}, 32'd1);
        @(posedge clk);
        frame_check(8'h81, 1);
        check("t5_total_pops", rd1, 32'd6);

        // 6: two stop bits, 0x00 twice
        sel = 1'b1;
        @(posedge clk); #1;
        push2(8'h00); push2(8'h00);
        n0 = pop_log2.size();
        wait_pop(5);
        frame_check(8'h00, 2);
        wait_pop(2);
        frame_check(8'h00, 2);
        check("t6_pops", pop_log2.size() - n0, 32'd2);
        if (pop_log2.size() - n0 == 2)
            check("t6_gap", pop_log2[n0 + 1] - pop_log2[n0], 32'd45);
        @(negedge clk);
        check("t6_idle_busy", {31'd0, busy2}, 32'd0);
        check("t6_idle_txd", {31'd0, txd2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
